as_uart_rx_ctrl: RTL and testbench

//  Receive-side sequencer for the UART baud-rate generator (as_br).
//  - Detects the start bit on rxd_i and restarts the generator via br_start_o.
//  - Samples each bit on the generator's mid-bit tick br2_i.
//  - Deserialises DATA_BITS data bits, LSB first, and checks the stop bit.
//  - Presents the received byte in a 1-entry holding register with a valid/rd handshake.

---
 rtl/as_uart_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_as_uart_rx_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/as_uart_rx_ctrl.sv
// rtl/as_uart_rx_ctrl.sv - UART receive sequencer driven by the as_br baud generator
// Synchronises rxd_i, frames start/data/stop on mid-bit ticks, holds one received byte.
module as_uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  input  logic                 br_i,
  input  logic                 br2_i,
  output logic                 br_start_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 rd_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_q;
  logic [DATA_BITS-1:0]   r_shift;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_rx_s;
  logic w_fall;
  logic w_load;
  logic w_stop_bad;
  logic w_unused_br;

  // The bit-boundary tick is only observed externally; sampling uses br2_i.
  assign w_unused_br = br_i;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_fall     = r_rx_q & ~w_rx_s;
  assign w_load     = (r_state == ST_STOP) & br2_i & w_rx_s;
  assign w_stop_bad = (r_state == ST_STOP) & br2_i & ~w_rx_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '1;
      r_rx_q <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd_i};
      r_rx_q <= w_rx_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) r_state <= ST_START;
        end
        ST_START: begin
          if (br2_i) begin
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (br2_i) begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + CW'(1);
            if (r_bit_cnt == CW'(DATA_BITS - 1)) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (br2_i) r_state <= w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start is accepted.
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (rd_i) begin
        r_valid <= 1'b0;
      end
      if (w_load && r_valid && !rd_i) begin
        r_overrun <= 1'b1;
      end else if (rd_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign br_start_o  = (r_state == ST_IDLE) & w_fall;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_as_uart_rx_ctrl.sv
// tb/tb_as_uart_rx_ctrl.sv - directed bench for as_uart_rx_ctrl with an as_br tick model
// Ticks: br2_i 8 clk after br_start_o, then every 16 clk; frames sent at 16 clk per bit.
module tb_as_uart_rx_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rxd_i;
  logic       br_i;
  logic       br2_i;
  logic       br_start_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       rd_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;
  logic run  = 1'b0;
  int fe_cnt = 0;
  int bs_cnt = 0;

  as_uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rxd_i       (rxd_i),
    .br_i        (br_i),
    .br2_i       (br2_i),
    .br_start_o  (br_start_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .rd_i        (rd_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run <= 1'b0;
      cnt <= 0;
    end else if (br_start_o) begin
      run <= 1'b1;
      cnt <= 0;
    end else if (run) begin
      cnt <= cnt + 1;
    end
  end

  assign br2_i = run && (cnt % 16 == 8);
  assign br_i  = run && (cnt % 16 == 0) && (cnt != 0);

  always @(negedge clk_i) begin
    if (frame_err_o) fe_cnt <= fe_cnt + 1;
    if (br_start_o)  bs_cnt <= bs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    rxd_i = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      idle(16);
    end
    rxd_i = stop;
    idle(stop_len);
  endtask

  // Stops on the cycle whose br2_i is the STOP-state sample (10th tick after br_start_o).
  task automatic wait_load(output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!br_start_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    while (!(run && cnt == 152) && n < 800) begin
      @(negedge clk_i);
      n++;
    end
    ok = (n < 800);
  endtask

  logic ok;
  int   fe0;
  int   bs0;

  initial begin
    rst_i = 1'b1;
    rxd_i = 1'b1;
    rd_i  = 1'b0;
    idle(3);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_br_start", br_start_o, 0);
    rst_i = 1'b0;
    idle(5);

    // 1: clean 0xA5 frame, exact load latency
    fe0 = fe_cnt;
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        wait_load(ok);
        check("t1_load_seen", ok, 1);
        check("t1_valid_before", valid_o, 0);
        @(negedge clk_i);
        check("t1_valid_after", valid_o, 1);
        check("t1_data", data_o, 8'hA5);
        check("t1_busy", busy_o, 0);
      end
    join
    idle(4);
    check("t1_frame_err", fe_cnt - fe0, 0);
    rd_i = 1'b1;
    idle(1);
    rd_i = 1'b0;
    check("t1_rd_clears", valid_o, 0);
    idle(4);

    // 2: short low glitch rejected in START
    fe0 = fe_cnt;
    bs0 = bs_cnt;
    rxd_i = 1'b0;
    idle(4);
    rxd_i = 1'b1;
    idle(1);
    check("t2_busy_start", busy_o, 1);
    idle(30);
    check("t2_busy_idle", busy_o, 0);
    check("t2_valid", valid_o, 0);
    check("t2_br_start_once", bs_cnt - bs0, 1);
    check("t2_no_frame_err", fe_cnt - fe0, 0);

    // 3: bad stop bit, line held low
    fe0 = fe_cnt;
    bs0 = bs_cnt;
    send_frame(8'h3C, 1'b0, 40);
    check("t3_frame_err_1cyc", fe_cnt - fe0, 1);
    check("t3_valid", valid_o, 0);
    check("t3_busy_wait_high", busy_o, 1);
    rxd_i = 1'b1;
    idle(5);
    check("t3_busy_idle", busy_o, 0);
    check("t3_no_retrigger", bs_cnt - bs0, 1);
    idle(4);

    // 4: overrun
    send_frame(8'h11, 1'b1, 16);
    idle(4);
    check("t4_valid1", valid_o, 1);
    check("t4_overrun0", overrun_o, 0);
    send_frame(8'h22, 1'b1, 16);
    idle(4);
    check("t4_overrun1", overrun_o, 1);
    check("t4_data", data_o, 8'h22);
    check("t4_valid2", valid_o, 1);
    rd_i = 1'b1;
    idle(1);
    rd_i = 1'b0;
    check("t4_rd_valid", valid_o, 0);
    check("t4_rd_overrun", overrun_o, 0);
    idle(4);

    // 5: rd_i coincident with load of a second byte
    send_frame(8'h33, 1'b1, 16);
    idle(4);
    check("t5_valid_first", valid_o, 1);
    fork
      send_frame(8'h44, 1'b1, 16);
      begin
        wait_load(ok);
        check("t5_load_seen", ok, 1);
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        check("t5_valid", valid_o, 1);
        check("t5_overrun", overrun_o, 0);
        check("t5_data", data_o, 8'h44);
      end
    join
    idle(4);

    // 6: reset during data bit 3, then a clean 0x5A frame
    check("t6_valid_pre", valid_o, 1);
    rxd_i = 1'b0;
    idle(16);
    rxd_i = 1'b1;
    idle(16);
    rxd_i = 1'b0;
    idle(16);
    rxd_i = 1'b1;
    idle(16);
    rxd_i = 1'b0;
    idle(8);
    check("t6_busy_pre", busy_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_data", data_o, 0);
    check("t6_rst_overrun", overrun_o, 0);
    rxd_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    idle(20);
    check("t6_valid_idle", valid_o, 0);
    fe0 = fe_cnt;
    send_frame(8'h5A, 1'b1, 16);
    idle(4);
    check("t6_valid", valid_o, 1);
    check("t6_data", data_o, 8'h5A);
    check("t6_overrun", overrun_o, 0);
    check("t6_frame_err", fe_cnt - fe0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
